dbus_master_ctrl: RTL and testbench
===================================

// Module: dbus_master_ctrl
// PURPOSE
//  Data-bus master between core LSU request channel and a stb/ack/err memory slave (bytewrite RAM or error-injecting wrap).
//  Registers one request, holds stb until ack/err/timeout, returns one-cycle response with read data or error status.
//  Records the address of the last faulting access and a saturating error count for debug/trap logic.
// PARAMETERS
//  TIMEOUT_CYCLES  16  max cycles stb may stay high without ack/err (>=2); used only with DBUS_TIMEOUT_EN
//  ERR_CNT_W       8   width of saturating error counter
// PORTS
//  clk_i          in   1   clock; all state on rising edge
//  rst_i          in   1   asynchronous, active-high reset
//  req_valid_i    in   1   core request valid
//  req_ready_o    out  1   controller accepts request (IDLE only)
//  req_we_i       in   4   byte write enables; 4'b0000 = read
//  req_addr_i     in   `DATA_WIDTH  byte address
//  req_wdata_i    in   `DATA_WIDTH  write data
//  rsp_valid_o    out  1   response valid, one-cycle pulse
//  rsp_rdata_o    out  `DATA_WIDTH  read data (valid with rsp_valid_o, ack, read)
//  rsp_err_o      out  1   access ended by err_i or timeout
//  rsp_timeout_o  out  1   access ended by timeout
//  stb_o          out  1   bus strobe, level; held until completion
//  we_o           out  4   bus byte write enables
//  addr_o         out  `DATA_WIDTH  bus address
//  wdata_o        out  `DATA_WIDTH  bus write data
//  rdata_i        in   `DATA_WIDTH  bus read data, sampled on ack_i
//  ack_i          in   1   slave success
//  err_i          in   1   slave error
//  err_addr_o     out  `DATA_WIDTH  address of last errored/timed-out access
//  err_cnt_o      out  ERR_CNT_W   saturating count of errored/timed-out accesses
// BEHAVIOUR
//  Reset: all outputs 0 except req_ready_o=1; FSM=IDLE; counters 0. Async assert drops stb_o immediately; in-flight access discarded, no response.
//  FSM: IDLE -> WAIT -> RESP -> IDLE. All outputs registered.
//  IDLE: req_ready_o=1. req_valid_i high at edge: latch we/addr/wdata to bus regs, stb_o=1 and req_ready_o=0 from next cycle, go WAIT.
//  WAIT: stb_o, we_o, addr_o, wdata_o stable. Completion at edge where:
//   err_i=1 (wins over ack_i): rsp_err=1, err_addr_o<=addr_o, err_cnt++ (saturate at all-ones).
//   ack_i=1, err_i=0: rsp_rdata<=rdata_i (reads; writes leave it unchanged), rsp_err=0.
//  On completion stb_o=0 next cycle, go RESP. RESP: rsp_valid_o=1 for exactly that cycle, req_ready_o=0; then IDLE.
//  Minimum request-to-response: accept edge + 1 cycle WAIT + RESP = rsp_valid 2 cycles after accept when ack in first WAIT cycle.
//  ack_i/err_i outside WAIT: ignored, no state change.
//  rsp_err_o/rsp_timeout_o/rsp_rdata_o hold value until next response; meaningful only with rsp_valid_o.
// CONFIGURATION
//  DBUS_TIMEOUT_EN defined: wait counter cleared on entering WAIT, +1 per WAIT cycle; at count TIMEOUT_CYCLES-1
//   with no ack_i/err_i, complete with rsp_err=1, rsp_timeout=1, update err_addr/err_cnt. ack_i or err_i on that same edge wins.
//  Undefined: no counter; WAIT lasts until ack_i/err_i; rsp_timeout_o tied 0.
// STRUCTURE
//  jedro_1_defines.v: `DATA_WIDTH, FSM state encodings (IDLE/WAIT/RESP).
//  Sub-module dbus_timeout_cnt (clear, enable, expired), instantiated only under DBUS_TIMEOUT_EN.
// TESTING
//  Read, slave acks 1 cycle after stb, rdata_i=32'hDEADBEEF -> one rsp_valid, rdata=32'hDEADBEEF, rsp_err=0, stb_o low next cycle.
//  Write we=4'b0011 to error wrap at 0x100 (err 2 cycles after stb, ack=0) -> rsp_err=1, err_addr_o=0x100, err_cnt_o=1, stb_o held until err.
//  DBUS_TIMEOUT_EN, slave silent -> stb high exactly 16 cycles, rsp_err=1, rsp_timeout=1, err_cnt increments.
//  ack_i and err_i same edge -> rsp_err=1, rdata unchanged; ack on timeout edge -> rsp_err=0, rsp_timeout=0.
//  rst_i pulsed during WAIT -> stb_o low asynchronously, no rsp_valid, req_ready_o=1, err_cnt_o=0.
//  ERR_CNT_W=2, five error accesses -> err_cnt_o sequence 1,2,3,3,3; back-to-back req_valid -> accepted only in IDLE.

Source files
------------

// File: rtl/dbus_master_ctrl_pkg.sv
// Shared types and constants for the data-bus master controller.
package dbus_master_ctrl_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned WE_W       = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // All byte enables clear marks a read access.
  function automatic logic is_read(input logic [WE_W-1:0] we);
    return (we == 4'b0000);
  endfunction

endpackage

// File: rtl/dbus_master_ctrl_if.sv
// Core request/response channel plus stb/ack/err bus, as seen by the controller (master)
// and by its environment (slave: LSU driver and memory slave together).
interface dbus_master_ctrl_if #(
  parameter int unsigned ERR_CNT_W = 8
);
  import dbus_master_ctrl_pkg::*;

  logic                  req_valid_i;
  logic                  req_ready_o;
  logic [WE_W-1:0]       req_we_i;
  logic [DATA_WIDTH-1:0] req_addr_i;
  logic [DATA_WIDTH-1:0] req_wdata_i;
  logic                  rsp_valid_o;
  logic [DATA_WIDTH-1:0] rsp_rdata_o;
  logic                  rsp_err_o;
  logic                  rsp_timeout_o;
  logic                  stb_o;
  logic [WE_W-1:0]       we_o;
  logic [DATA_WIDTH-1:0] addr_o;
  logic [DATA_WIDTH-1:0] wdata_o;
  logic [DATA_WIDTH-1:0] rdata_i;
  logic                  ack_i;
  logic                  err_i;
  logic [DATA_WIDTH-1:0] err_addr_o;
  logic [ERR_CNT_W-1:0]  err_cnt_o;

  modport master (
    input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, rdata_i, ack_i, err_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
           stb_o, we_o, addr_o, wdata_o, err_addr_o, err_cnt_o
  );

  modport slave (
    output req_valid_i, req_we_i, req_addr_i, req_wdata_i, rdata_i, ack_i, err_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
           stb_o, we_o, addr_o, wdata_o, err_addr_o, err_cnt_o
  );

endinterface

// File: rtl/dbus_master_ctrl_timeout_cnt.sv
// Wait-state counter for the bus master; expired_o flags the last allowed strobe cycle.
module dbus_timeout_cnt #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned     CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Hold at LAST so the count never wraps back into a fresh window.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && !expired_o) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/dbus_master_ctrl.sv
// Data-bus master: one registered request, stb held until ack/err, one-cycle response.
// Optional wait-state timeout enabled by defining DBUS_TIMEOUT_EN.
module dbus_master_ctrl
  import dbus_master_ctrl_pkg::*;
#(
`ifdef DBUS_TIMEOUT_EN
  parameter int unsigned TIMEOUT_CYCLES = 16,
`endif
  parameter int unsigned ERR_CNT_W = 8
) (
  input logic                clk_i,
  input logic                rst_i,
  dbus_master_ctrl_if.master dbus
);

  state_e                state_q, state_d;
  logic                  req_ready_q, req_ready_d;
  logic                  stb_q, stb_d;
  logic [WE_W-1:0]       we_q, we_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  rsp_timeout_q, rsp_timeout_d;
  logic [DATA_WIDTH-1:0] err_addr_q, err_addr_d;
  logic [ERR_CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic                  timeout_expired;

`ifdef DBUS_TIMEOUT_EN
  dbus_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (state_q != ST_WAIT),
    .en_i      (state_q == ST_WAIT),
    .expired_o (timeout_expired)
  );
`else
  assign timeout_expired = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    req_ready_d   = req_ready_q;
    stb_d         = stb_q;
    we_d          = we_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    err_addr_d    = err_addr_q;
    err_cnt_d     = err_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (dbus.req_valid_i) begin
          we_d        = dbus.req_we_i;
          addr_d      = dbus.req_addr_i;
          wdata_d     = dbus.req_wdata_i;
          stb_d       = 1'b1;
          req_ready_d = 1'b0;
          state_d     = ST_WAIT;
        end else begin
          req_ready_d = 1'b1;
        end
      end
      ST_WAIT: begin
        // Priority err > ack > timeout; a late ack still beats the timeout edge.
        if (dbus.err_i || (timeout_expired && !dbus.ack_i)) begin
          rsp_err_d     = 1'b1;
          rsp_timeout_d = !dbus.err_i;
          err_addr_d    = addr_q;
          err_cnt_d     = (&err_cnt_q) ? err_cnt_q : err_cnt_q + ERR_CNT_W'(1);
        end else if (dbus.ack_i) begin
          rsp_err_d     = 1'b0;
          rsp_timeout_d = 1'b0;
          if (is_read(we_q)) begin
            rsp_rdata_d = dbus.rdata_i;
          end else begin
            rsp_rdata_d = rsp_rdata_q;
          end
        end else begin
          rsp_err_d = rsp_err_q;
        end
        if (dbus.err_i || dbus.ack_i || timeout_expired) begin
          stb_d       = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else begin
          stb_d = 1'b1;
        end
      end
      ST_RESP: begin
        req_ready_d = 1'b1;
        state_d     = ST_IDLE;
      end
      default: begin
        stb_d       = 1'b0;
        req_ready_d = 1'b1;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      req_ready_q   <= 1'b1;
      stb_q         <= 1'b0;
      we_q          <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      err_addr_q    <= '0;
      err_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      req_ready_q   <= req_ready_d;
      stb_q         <= stb_d;
      we_q          <= we_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
      err_addr_q    <= err_addr_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  assign dbus.req_ready_o   = req_ready_q;
  assign dbus.stb_o         = stb_q;
  assign dbus.we_o          = we_q;
  assign dbus.addr_o        = addr_q;
  assign dbus.wdata_o       = wdata_q;
  assign dbus.rsp_valid_o   = rsp_valid_q;
  assign dbus.rsp_rdata_o   = rsp_rdata_q;
  assign dbus.rsp_err_o     = rsp_err_q;
  assign dbus.rsp_timeout_o = rsp_timeout_q;
  assign dbus.err_addr_o    = err_addr_q;
  assign dbus.err_cnt_o     = err_cnt_q;

endmodule

// File: tb/tb_dbus_master_ctrl.sv
// Directed scoreboard bench for dbus_master_ctrl (ERR_CNT_W=2 to reach saturation).
module tb_dbus_master_ctrl;
  import dbus_master_ctrl_pkg::*;

  localparam int unsigned CW = 2;
  localparam int K_ACK = 0;
  localparam int K_ERR = 1;
  localparam int K_TMO = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;

  dbus_master_ctrl_if #(.ERR_CNT_W(CW)) ifc ();

  dbus_master_ctrl #(.ERR_CNT_W(CW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .dbus  (ifc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        tmo;
  } rsp_t;

  rsp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          stb_cycles;
  logic [31:0] model_rdata;
  logic [31:0] model_err_addr;
  logic [CW-1:0] model_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: err wins over ack, ack wins over timeout.
  task automatic predict(input int kind, input logic [3:0] we, input logic [31:0] addr,
                         input logic [31:0] rd);
    rsp_t r;
    if (kind == K_ACK) begin
      r.err = 1'b0;
      r.tmo = 1'b0;
      if (we == 4'b0000) model_rdata = rd;
    end else begin
      r.err = 1'b1;
      r.tmo = (kind == K_TMO);
      model_err_addr = addr;
      if (model_cnt != {CW{1'b1}}) model_cnt = model_cnt + 2'd1;
    end
    r.rdata = model_rdata;
    exp_q.push_back(r);
  endtask

  task automatic issue(input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wdata);
    check("ready_before_req", ifc.req_ready_o, 32'd1);
    ifc.req_valid_i = 1'b1;
    ifc.req_we_i    = we;
    ifc.req_addr_i  = addr;
    ifc.req_wdata_i = wdata;
    @(negedge clk);
    ifc.req_valid_i = 1'b0;
    check("stb_after_accept", ifc.stb_o, 32'd1);
    check("ready_low_in_wait", ifc.req_ready_o, 32'd0);
    check("we_o", {28'd0, ifc.we_o}, {28'd0, we});
    check("addr_o", ifc.addr_o, addr);
    check("wdata_o", ifc.wdata_o, wdata);
  endtask

  task automatic wait_rsp(input int budget);
    rsp_t e;
    int   n;
    n = 0;
    while (ifc.rsp_valid_o !== 1'b1 && n < budget) begin
      @(negedge clk);
      ifc.ack_i = 1'b0;
      ifc.err_i = 1'b0;
      n++;
    end
    check("rsp_valid_seen", ifc.rsp_valid_o, 32'd1);
    check("sb_pending", (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("rsp_rdata", ifc.rsp_rdata_o, e.rdata);
      check("rsp_err", ifc.rsp_err_o, {31'd0, e.err});
      check("rsp_timeout", ifc.rsp_timeout_o, {31'd0, e.tmo});
    end
    check("err_addr", ifc.err_addr_o, model_err_addr);
    check("err_cnt", {30'd0, ifc.err_cnt_o}, {30'd0, model_cnt});
    check("stb_low_in_resp", ifc.stb_o, 32'd0);
    check("ready_low_in_resp", ifc.req_ready_o, 32'd0);
    @(negedge clk);
    check("rsp_valid_pulse", ifc.rsp_valid_o, 32'd0);
    check("ready_back_idle", ifc.req_ready_o, 32'd1);
    check("stb_low_idle", ifc.stb_o, 32'd0);
  endtask

  task automatic respond(input int delay, input logic ack, input logic err, input logic [31:0] rd,
                         input logic [31:0] addr);
    for (int i = 1; i < delay; i++) begin
      check("stb_held", ifc.stb_o, 32'd1);
      check("addr_stable", ifc.addr_o, addr);
      check("no_early_rsp", ifc.rsp_valid_o, 32'd0);
      @(negedge clk);
    end
    ifc.ack_i   = ack;
    ifc.err_i   = err;
    ifc.rdata_i = rd;
    wait_rsp(4);
  endtask

  task automatic access(input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wdata,
                        input int delay, input logic ack, input logic err, input logic [31:0] rd);
    predict(err ? K_ERR : K_ACK, we, addr, rd);
    issue(we, addr, wdata);
    respond(delay, ack, err, rd, addr);
  endtask

  initial begin
    ifc.req_valid_i = 1'b0;
    ifc.req_we_i    = 4'b0000;
    ifc.req_addr_i  = 32'd0;
    ifc.req_wdata_i = 32'd0;
    ifc.rdata_i     = 32'd0;
    ifc.ack_i       = 1'b0;
    ifc.err_i       = 1'b0;
    model_rdata     = 32'd0;
    model_err_addr  = 32'd0;
    model_cnt       = 2'd0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ready", ifc.req_ready_o, 32'd1);
    check("rst_stb", ifc.stb_o, 32'd0);
    check("rst_rsp_valid", ifc.rsp_valid_o, 32'd0);
    check("rst_err_cnt", {30'd0, ifc.err_cnt_o}, 32'd0);
    check("rst_err_addr", ifc.err_addr_o, 32'd0);
    check("rst_rdata", ifc.rsp_rdata_o, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    access(4'b0000, 32'h0000_0040, 32'd0, 1, 1'b1, 1'b0, 32'hDEADBEEF);
    access(4'b0011, 32'h0000_0100, 32'h0000_A5A5, 2, 1'b0, 1'b1, 32'd0);
    access(4'b1111, 32'h0000_0200, 32'h0000_0001, 3, 1'b1, 1'b0, 32'hFFFF_0000);
    access(4'b0000, 32'h0000_0300, 32'd0, 1, 1'b1, 1'b1, 32'h1234_5678);

    // Bus handshakes outside WAIT must not disturb anything.
    ifc.ack_i = 1'b1;
    ifc.err_i = 1'b1;
    repeat (3) @(negedge clk);
    ifc.ack_i = 1'b0;
    ifc.err_i = 1'b0;
    check("idle_ack_cnt", {30'd0, ifc.err_cnt_o}, {30'd0, model_cnt});
    check("idle_ack_rsp", ifc.rsp_valid_o, 32'd0);
    check("idle_ack_stb", ifc.stb_o, 32'd0);
    check("idle_ack_ready", ifc.req_ready_o, 32'd1);

    for (int i = 0; i < 3; i++) begin
      access(4'b0000, 32'h0000_0400 + 32'(i * 4), 32'd0, 1 + i, 1'b0, 1'b1, 32'd0);
    end
    check("err_cnt_saturated", {30'd0, ifc.err_cnt_o}, 32'd3);

    // Back-to-back: req_valid held high through a whole access.
    predict(K_ACK, 4'b0000, 32'h0000_0500, 32'h1111_2222);
    predict(K_ACK, 4'b0000, 32'h0000_0504, 32'h3333_4444);
    ifc.req_valid_i = 1'b1;
    ifc.req_we_i    = 4'b0000;
    ifc.req_addr_i  = 32'h0000_0500;
    @(negedge clk);
    check("b2b_stb1", ifc.stb_o, 32'd1);
    check("b2b_addr1", ifc.addr_o, 32'h0000_0500);
    ifc.req_addr_i = 32'h0000_0504;
    @(negedge clk);
    check("b2b_addr_stable", ifc.addr_o, 32'h0000_0500);
    check("b2b_ready_wait", ifc.req_ready_o, 32'd0);
    ifc.ack_i   = 1'b1;
    ifc.rdata_i = 32'h1111_2222;
    wait_rsp(4);
    @(negedge clk);
    ifc.req_valid_i = 1'b0;
    check("b2b_stb2", ifc.stb_o, 32'd1);
    check("b2b_addr2", ifc.addr_o, 32'h0000_0504);
    ifc.ack_i   = 1'b1;
    ifc.rdata_i = 32'h3333_4444;
    wait_rsp(4);

`ifdef DBUS_TIMEOUT_EN
    predict(K_TMO, 4'b0000, 32'h0000_0700, 32'd0);
    issue(4'b0000, 32'h0000_0700, 32'd0);
    stb_cycles = 0;
    while (ifc.stb_o === 1'b1 && stb_cycles < 64) begin
      stb_cycles++;
      @(negedge clk);
    end
    check("tmo_stb_cycles", 32'(stb_cycles), 32'd16);
    wait_rsp(1);
    predict(K_ACK, 4'b0000, 32'h0000_0704, 32'h0000_CAFE);
    issue(4'b0000, 32'h0000_0704, 32'd0);
    repeat (15) @(negedge clk);
    check("tmo_edge_stb", ifc.stb_o, 32'd1);
    ifc.ack_i   = 1'b1;
    ifc.rdata_i = 32'h0000_CAFE;
    wait_rsp(4);
`endif

    // Asynchronous reset in the middle of a WAIT discards the access.
    issue(4'b0000, 32'h0000_0600, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("arst_stb", ifc.stb_o, 32'd0);
    check("arst_ready", ifc.req_ready_o, 32'd1);
    check("arst_err_cnt", {30'd0, ifc.err_cnt_o}, 32'd0);
    check("arst_rsp_valid", ifc.rsp_valid_o, 32'd0);
    @(negedge clk);
    rst            = 1'b0;
    model_cnt      = 2'd0;
    model_err_addr = 32'd0;
    model_rdata    = 32'd0;
    ifc.ack_i      = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_no_rsp", ifc.rsp_valid_o, 32'd0);
    end
    ifc.ack_i = 1'b0;
    check("post_rst_err_addr", ifc.err_addr_o, 32'd0);
    check("post_rst_rdata", ifc.rsp_rdata_o, 32'd0);

    access(4'b0000, 32'h0000_0800, 32'd0, 2, 1'b0, 1'b1, 32'd0);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
